cmd_status_tracker: RTL and testbench

CMD_STATUS_TRACKER -- requirements
Module: cmd_status_tracker

---
 rtl/cmd_status_tracker.sv | 178 +++++++++++++++++
 tb/tb_cmd_status_tracker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_status_tracker.sv
// Command/status tracker: buffers upstream commands in a FIFO, issues them to
// a bus with a cap on commands in flight, and pairs each returned bus status
// with the ID of the oldest issued command before presenting it upstream.
module cmd_status_tracker #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ID_WIDTH        = 4,
    parameter int CNT_WIDTH       = 8,
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_command_valid,
    output logic                 o_command_ready,
    input  logic                 i_command,
    input  logic [ID_WIDTH-1:0]  i_command_id,
    output logic                 o_bus_command_valid,
    input  logic                 i_bus_command_ready,
    output logic                 o_bus_command,
    output logic [ID_WIDTH-1:0]  o_bus_command_id,
    input  logic                 i_bus_status_valid,
    output logic                 o_bus_status_ready,
    input  logic                 i_bus_status,
    output logic                 o_status_valid,
    input  logic                 i_status_ready,
    output logic                 o_status,
    output logic [ID_WIDTH-1:0]  o_status_id,
    output logic [OUT_W-1:0]     o_outstanding,
    output logic [CNT_WIDTH-1:0] o_error_count,
    output logic                 o_unexpected_status
);

    localparam int AW = $clog2(DEPTH);
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    // ------------------------------------------------------------------
    // Command FIFO (entry = {command, id}); pointers carry a wrap bit.
    // ------------------------------------------------------------------
    logic [ID_WIDTH:0] fifo_mem [DEPTH];
    logic [AW:0]       fifo_wr_reg;
    logic [AW:0]       fifo_rd_reg;
    logic              fifo_full;
    logic              fifo_empty;
    logic              cmd_push;
    logic              bus_issue;

    assign fifo_empty = (fifo_wr_reg == fifo_rd_reg);
    assign fifo_full  = (fifo_wr_reg[AW] != fifo_rd_reg[AW]) &&
                        (fifo_wr_reg[AW-1:0] == fifo_rd_reg[AW-1:0]);

    assign o_command_ready = !fifo_full;
    assign cmd_push        = i_command_valid && !fifo_full;

    // Head of FIFO drives the bus payload directly; a freshly written entry is
    // only visible once the write pointer has moved, so there is no bypass.
    assign {o_bus_command, o_bus_command_id} = fifo_mem[fifo_rd_reg[AW-1:0]];

    // FIFO storage write (data path, no reset needed)
    always_ff @(posedge i_clk) begin
        if (cmd_push) begin
            fifo_mem[fifo_wr_reg[AW-1:0]] <= {i_command, i_command_id};
        end
    end

    // FIFO pointer update
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fifo_wr_reg <= '0;
            fifo_rd_reg <= '0;
        end else begin
            if (cmd_push) begin
                fifo_wr_reg <= fifo_wr_reg + (AW + 1)'(1);
            end
            if (bus_issue) begin
                fifo_rd_reg <= fifo_rd_reg + (AW + 1)'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // In-order ID queue of issued commands. MAX_OUTSTANDING need not be a
    // power of two, so the index wraps explicitly and toggles the wrap bit.
    // ------------------------------------------------------------------
    logic [QW:0]         id_wr_reg;
    logic [QW:0]         id_rd_reg;
    logic                id_full;
    logic                id_empty;
    logic                bus_done;
    logic [ID_WIDTH-1:0] id_slots [MAX_OUTSTANDING];

    function automatic logic [QW:0] qptr_next(input logic [QW:0] p);
        if (p[QW-1:0] == QW'(MAX_OUTSTANDING - 1)) begin
            qptr_next = {~p[QW], {QW{1'b0}}};
        end else begin
            qptr_next = p + (QW + 1)'(1);
        end
    endfunction

    assign id_empty = (id_wr_reg == id_rd_reg);
    assign id_full  = (id_wr_reg[QW] != id_rd_reg[QW]) &&
                      (id_wr_reg[QW-1:0] == id_rd_reg[QW-1:0]);

    assign o_bus_command_valid = !fifo_empty && !id_full;
    assign bus_issue           = o_bus_command_valid && i_bus_command_ready;

    assign o_bus_status_ready  = !id_empty && (!o_status_valid || i_status_ready);
    assign bus_done            = i_bus_status_valid && o_bus_status_ready;

    // One register per ID slot; each captures the issued ID when it is the write target
    for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_id_slot
        logic [ID_WIDTH-1:0] slot_reg;
        always_ff @(posedge i_clk) begin
            if (bus_issue && (id_wr_reg[QW-1:0] == QW'(gi))) begin
                slot_reg <= o_bus_command_id;
            end
        end
        assign id_slots[gi] = slot_reg;
    end

    // ID queue pointer update
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            id_wr_reg <= '0;
            id_rd_reg <= '0;
        end else begin
            if (bus_issue) begin
                id_wr_reg <= qptr_next(id_wr_reg);
            end
            if (bus_done) begin
                id_rd_reg <= qptr_next(id_rd_reg);
            end
        end
    end

    // Outstanding count: issue and completion in the same cycle cancel out
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_outstanding <= '0;
        end else begin
            case ({bus_issue, bus_done})
                2'b10:   o_outstanding <= o_outstanding + OUT_W'(1);
                2'b01:   o_outstanding <= o_outstanding - OUT_W'(1);
                default: o_outstanding <= o_outstanding;
            endcase
        end
    end

    // Upstream status register: load on bus completion, clear once taken
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_status_valid <= 1'b0;
            o_status       <= 1'b0;
            o_status_id    <= '0;
        end else if (bus_done) begin
            o_status_valid <= 1'b1;
            o_status       <= i_bus_status;
            o_status_id    <= id_slots[id_rd_reg[QW-1:0]];
        end else if (i_status_ready) begin
            o_status_valid <= 1'b0;
        end
    end

    // Saturating ERROR counter and sticky unexpected-status flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_error_count       <= '0;
            o_unexpected_status <= 1'b0;
        end else begin
            if (bus_done && i_bus_status && (o_error_count != '1)) begin
                o_error_count <= o_error_count + CNT_WIDTH'(1);
            end
            if (i_bus_status_valid && id_empty) begin
                o_unexpected_status <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmd_status_tracker.sv
// Self-checking bench for cmd_status_tracker: queue-based reference model
// compared every cycle, directed scenarios with literal expectations, then
// randomized traffic with occasional resets.
module tb_cmd_status_tracker;

    localparam int DEPTH   = 4;
    localparam int MAXO    = 2;
    localparam int IDW     = 4;
    localparam int CNTW    = 2;
    localparam int OUTW    = $clog2(MAXO + 1);
    localparam int ERR_MAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid, cmd, bcmd_ready, bst_valid, bst, st_ready;
    logic [IDW-1:0]  cmd_id;
    logic            cmd_ready, bcmd_valid, bcmd, bst_ready, st_valid, st;
    logic [IDW-1:0]  bcmd_id, st_id;
    logic [OUTW-1:0] outstanding;
    logic [CNTW-1:0] err_count;
    logic            unexp;

    cmd_status_tracker #(
        .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .ID_WIDTH(IDW), .CNT_WIDTH(CNTW)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_command_valid(cmd_valid), .o_command_ready(cmd_ready),
        .i_command(cmd), .i_command_id(cmd_id),
        .o_bus_command_valid(bcmd_valid), .i_bus_command_ready(bcmd_ready),
        .o_bus_command(bcmd), .o_bus_command_id(bcmd_id),
        .i_bus_status_valid(bst_valid), .o_bus_status_ready(bst_ready),
        .i_bus_status(bst),
        .o_status_valid(st_valid), .i_status_ready(st_ready),
        .o_status(st), .o_status_id(st_id),
        .o_outstanding(outstanding), .o_error_count(err_count),
        .o_unexpected_status(unexp)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (queues) ----------------
    typedef struct packed { logic c; logic [IDW-1:0] id; } cmd_t;
    typedef struct packed { logic [IDW-1:0] id; logic s; } up_t;

    cmd_t           m_cmdq[$];
    logic [IDW-1:0] m_idq[$];
    logic           m_sv, m_st, m_unexp;
    logic [IDW-1:0] m_sid;
    int             m_err;

    up_t up_log[$];
    int  n_bus;
    int  n_checks = 0;
    int  n_pass   = 0;
    bit  cmd_hs, bcmd_hs, bst_hs, ust_hs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // One clock: compare at negedge, advance model at posedge, return at posedge+1
    task automatic step();
        logic e_cr, e_bv, e_bsr;
        cmd_t h;
        @(negedge clk);
        e_cr  = m_cmdq.size() < DEPTH;
        e_bv  = (m_cmdq.size() != 0) && (m_idq.size() < MAXO);
        e_bsr = (m_idq.size() != 0) && (!m_sv || st_ready);
        chk("command_ready", cmd_ready, e_cr);
        chk("bus_command_valid", bcmd_valid, e_bv);
        chk("bus_status_ready", bst_ready, e_bsr);
        chk("status_valid", st_valid, m_sv);
        chk("status", st, m_st);
        chk("status_id", st_id, m_sid);
        chk("outstanding", outstanding, m_idq.size());
        chk("error_count", err_count, m_err);
        chk("unexpected_status", unexp, m_unexp);
        if (e_bv) begin
            chk("bus_command", bcmd, m_cmdq[0].c);
            chk("bus_command_id", bcmd_id, m_cmdq[0].id);
        end
        cmd_hs  = cmd_valid && e_cr;
        bcmd_hs = e_bv && bcmd_ready;
        bst_hs  = bst_valid && e_bsr;
        ust_hs  = m_sv && st_ready;
        if (bcmd_valid && bcmd_ready) n_bus++;
        if (st_valid && st_ready && !rst) begin
            up_log.push_back('{id: st_id, s: st});
            $display("upstream status id=%0d status=%0d t=%0t", st_id, st, $time);
        end
        @(posedge clk);
        if (rst) begin
            m_cmdq.delete(); m_idq.delete();
            m_sv = 0; m_st = 0; m_sid = '0; m_err = 0; m_unexp = 0;
        end else begin
            if (bst_valid && m_idq.size() == 0) m_unexp = 1;
            if (bst_hs) begin
                m_st  = bst;
                m_sid = m_idq.pop_front();
                m_sv  = 1;
                if (bst && m_err < ERR_MAX) m_err++;
            end else if (ust_hs) begin
                m_sv = 0;
            end
            if (bcmd_hs) begin
                h = m_cmdq.pop_front();
                m_idq.push_back(h.id);
            end
            if (cmd_hs) m_cmdq.push_back('{c: cmd, id: cmd_id});
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1; cmd_valid = 0; bst_valid = 0; bcmd_ready = 0; st_ready = 0;
        step(); step();
        rst = 0;
        n_bus = 0;
        up_log.delete();
    endtask

    task automatic send_cmd(input logic c, input logic [IDW-1:0] id);
        bit done = 0;
        cmd_valid = 1; cmd = c; cmd_id = id;
        for (int i = 0; i < 50 && !done; i++) begin
            step();
            done = cmd_hs;
        end
        cmd_valid = 0;
        chk("send_cmd_timeout", done, 1);
    endtask

    task automatic send_status(input logic s);
        bit done = 0;
        for (int i = 0; i < 50 && m_idq.size() == 0; i++) step();
        bst_valid = 1; bst = s;
        for (int i = 0; i < 50 && !done; i++) begin
            step();
            done = bst_hs;
        end
        bst_valid = 0;
        chk("send_status_timeout", done, 1);
    endtask

    initial begin
        rst = 1; cmd_valid = 0; cmd = 0; cmd_id = '0; bcmd_ready = 0;
        bst_valid = 0; bst = 0; st_ready = 0;
        m_sv = 0; m_st = 0; m_sid = '0; m_err = 0; m_unexp = 0; n_bus = 0;

        // Reset values and unexpected status with nothing outstanding
        do_reset();
        chk("rst_command_ready", cmd_ready, 1);
        chk("rst_bus_valid", bcmd_valid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_error_count", err_count, 0);
        bst_valid = 1; bst = 0;
        step();
        bst_valid = 0;
        chk("unexp_flag", unexp, 1);
        chk("unexp_no_status", st_valid, 0);
        step();
        chk("unexp_sticky", unexp, 1);

        // Basic ordered flow: IDs 1,2,3 with OK, ERROR, OK
        do_reset();
        bcmd_ready = 1; st_ready = 1;
        send_cmd(0, 4'd1); send_cmd(1, 4'd2); send_cmd(0, 4'd3);
        send_status(0); send_status(1); send_status(0);
        step(); step(); step();
        chk("flow_count", up_log.size(), 3);
        chk("flow_id0", up_log[0].id, 1); chk("flow_st0", up_log[0].s, 0);
        chk("flow_id1", up_log[1].id, 2); chk("flow_st1", up_log[1].s, 1);
        chk("flow_id2", up_log[2].id, 3); chk("flow_st2", up_log[2].s, 0);
        chk("flow_err", err_count, 1);

        // FIFO full back-pressure, then outstanding cap of 2
        do_reset();
        st_ready = 1;
        for (int k = 4; k < 8; k++) send_cmd(0, IDW'(k));
        chk("full_ready_low", cmd_ready, 0);
        cmd_valid = 1; cmd = 1; cmd_id = 4'd8;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("full_held", cmd_hs, 0);
        end
        bcmd_ready = 1;
        send_cmd(1, 4'd8);
        for (int k = 0; k < 5; k++) step();
        chk("cap_outstanding", outstanding, 2);
        chk("cap_bus_valid", bcmd_valid, 0);
        chk("cap_issued", n_bus, 2);

        // Upstream stall holds status; release accepts next bus status same cycle
        st_ready = 0;
        send_status(0);
        bst_valid = 1; bst = 1;
        for (int k = 0; k < 3; k++) step();
        chk("stall_bus_ready", bst_ready, 0);
        chk("stall_valid", st_valid, 1);
        chk("stall_id", st_id, 4);
        st_ready = 1;
        step();
        bst_valid = 0;
        chk("release_accept", bst_hs, 1);
        chk("release_valid", st_valid, 1);
        chk("release_id", st_id, 5);
        chk("release_status", st, 1);

        // Error counter saturation, then reset mid-stream
        do_reset();
        bcmd_ready = 1; st_ready = 1;
        for (int k = 0; k < 5; k++) begin
            send_cmd(1, IDW'(k));
            send_status(1);
        end
        step();
        chk("err_saturate", err_count, 3);
        send_cmd(0, 4'd9); send_cmd(0, 4'd10);
        step();
        rst = 1;
        step();
        rst = 0;
        chk("mid_rst_status_valid", st_valid, 0);
        chk("mid_rst_outstanding", outstanding, 0);
        chk("mid_rst_err", err_count, 0);
        chk("mid_rst_unexp", unexp, 0);
        chk("mid_rst_bus_valid", bcmd_valid, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_status", st, 0);
        chk("mid_rst_status_id", st_id, 0);

        // Randomized traffic with holding sources and rare resets
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 249) == 0);
            if (!(cmd_valid && !cmd_hs)) begin
                cmd_valid = ($urandom_range(0, 9) < 6);
                cmd       = 1'($urandom);
                cmd_id    = IDW'($urandom);
            end
            if (!(bst_valid && !bst_hs)) begin
                bst_valid = ((m_idq.size() != 0) && ($urandom_range(0, 1) == 1)) ||
                            ($urandom_range(0, 99) == 0);
                bst       = 1'($urandom);
            end
            bcmd_ready = ($urandom_range(0, 9) < 7);
            st_ready   = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
